// File: rtl/adc_avg_pkg.sv
// Shared constants, accumulator sizing and output FSM state type for the ADC sample averager.
package adc_avg_pkg;

  localparam int unsigned AVG_DATA_WIDTH = 12;
  localparam int unsigned AVG_LOG2       = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } avg_out_state_e;

  // A sum of 2**log2_avg words of data_w bits fits exactly in data_w+log2_avg bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned log2_avg);
    return data_w + log2_avg;
  endfunction

endpackage

// File: rtl/sample_edge_det.sv
// 1-bit rising-edge detector; the reset value of the history bit is a parameter so a level
// that is already high when reset releases does not register as an edge.
module sample_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= RST_VAL;
    else     r_q <= i_d;
  end

  assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Averages 2**LOG2_AVG consecutive ADC samples and holds the mean on a valid/ready output.
// Optional feature macro: AVG_MINMAX_EN adds per-window out_min/out_max.
module adc_sample_averager
  import adc_avg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AVG_DATA_WIDTH,
  parameter int unsigned LOG2_AVG   = AVG_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  input  logic                  clr_overrun
`ifdef AVG_MINMAX_EN
  ,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [DATA_WIDTH-1:0] out_max
`endif
);

  localparam int unsigned      ACC_W    = acc_width(DATA_WIDTH, LOG2_AVG);
  localparam int unsigned      CNT_W    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  function automatic logic [DATA_WIDTH-1:0] trunc_mean(input logic [ACC_W-1:0] sum);
    return DATA_WIDTH'(sum >> LOG2_AVG);
  endfunction

  logic           w_accept;
  logic           w_take;
  logic           w_last;
  logic           w_ovr_set;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  avg_out_state_e r_state;
  avg_out_state_e w_state_nxt;

  sample_edge_det #(
    .RST_VAL(1'b1)
  ) u_valid_edge (
    .clk   (clk),
    .rst   (rst),
    .i_d   (in_valid),
    .o_rise(w_accept)
  );

  // flush outranks a same-cycle accept, so the sample is dropped rather than seeding a window
  assign w_take = w_accept & ~flush;
  assign w_last = w_take & (r_cnt == CNT_LAST);
  assign w_sum  = r_acc + ACC_W'(in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (flush || w_last) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_take) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_last) w_state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (w_last)         w_ovr_set   = ~out_ready;
        else if (out_ready) w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  assign out_valid = (r_state == ST_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_data <= '0;
    else if (w_last) out_data <= trunc_mean(w_sum);
  end

  // A new overrun wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overrun <= 1'b0;
    else if (w_ovr_set)   overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

`ifdef AVG_MINMAX_EN
  function automatic logic [DATA_WIDTH-1:0] min_of(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] max_of(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_WIDTH-1:0] r_min;
  logic [DATA_WIDTH-1:0] r_max;
  logic [DATA_WIDTH-1:0] w_win_min;
  logic [DATA_WIDTH-1:0] w_win_max;

  // The first sample of a window (cnt==0) reseeds both extremes.
  assign w_win_min = (r_cnt == '0) ? in_data : min_of(r_min, in_data);
  assign w_win_max = (r_cnt == '0) ? in_data : max_of(r_max, in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min   <= '0;
      r_max   <= '0;
      out_min <= '0;
      out_max <= '0;
    end else begin
      if (w_take) begin
        r_min <= w_win_min;
        r_max <= w_win_max;
      end
      if (w_last) begin
        out_min <= w_win_min;
        out_max <= w_win_max;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager: directed scenarios plus a randomized run
// against a queue-based window model; a second instance covers the LOG2_AVG=0 passthrough.
module tb_adc_sample_averager;

  localparam int DW = 12;
  localparam int L2 = 2;
  localparam int N  = 1 << L2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          flush;
  logic          out_ready;
  logic          clr_overrun;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          overrun;
  logic [DW-1:0] p_out_data;
  logic          p_out_valid;
  logic          p_overrun;
`ifdef AVG_MINMAX_EN
  logic [DW-1:0] out_min, out_max, p_out_min, p_out_max;
`endif

  int vectors = 0;
  int errors  = 0;

  // behavioural model state
  int            win[$];
  logic          m_prev;
  logic          m_valid, m_ovr;
  logic [DW-1:0] m_data, m_min, m_max;
  logic          pm_valid;
  logic [DW-1:0] pm_data;

  always #5 clk = ~clk;

  adc_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(L2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .clr_overrun(clr_overrun)
`ifdef AVG_MINMAX_EN
    , .out_min(out_min), .out_max(out_max)
`endif
  );

  adc_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(0)) dut_pass (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .flush(1'b0),
    .out_data(p_out_data), .out_valid(p_out_valid), .out_ready(1'b1),
    .overrun(p_overrun), .clr_overrun(1'b0)
`ifdef AVG_MINMAX_EN
    , .out_min(p_out_min), .out_max(p_out_max)
`endif
  );

  task automatic model_reset();
    win.delete();
    m_prev = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0;
    m_data = '0; m_min = '0; m_max = '0;
    pm_valid = 1'b0; pm_data = '0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic acc, res;
    logic [DW-1:0] mean, mn, mx;
    int sum;
    if (rst) begin
      model_reset();
      return;
    end
    acc = in_valid && !m_prev;
    res = 1'b0; mean = '0; mn = '0; mx = '0;
    if (acc) begin
      pm_valid = 1'b1;
      pm_data  = in_data;
    end else begin
      pm_valid = 1'b0;
    end
    if (flush) begin
      win.delete();
    end else if (acc) begin
      win.push_back(int'(in_data));
      if (win.size() == N) begin
        sum = 0; mn = '1; mx = '0;
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] < int'(mn)) mn = DW'(win[i]);
          if (win[i] > int'(mx)) mx = DW'(win[i]);
        end
        mean = DW'(sum / N);
        win.delete();
        res = 1'b1;
      end
    end
    if (res) begin
      if (m_valid && !out_ready) m_ovr = 1'b1;
      else if (clr_overrun)      m_ovr = 1'b0;
      m_valid = 1'b1; m_data = mean; m_min = mn; m_max = mx;
    end else begin
      if (clr_overrun) m_ovr = 1'b0;
      if (m_valid && out_ready) m_valid = 1'b0;
    end
    m_prev = in_valid;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic sample_hi(input logic [DW-1:0] v);
    in_data = v;
    in_valid = 1'b1;
    tick();
  endtask

  task automatic sample_lo();
    in_valid = 1'b0;
    in_data = DW'($urandom_range(0, (1 << DW) - 1));
    tick();
  endtask

  task automatic send(input logic [DW-1:0] v);
    sample_hi(v);
    sample_lo();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 12'h123; flush = 1'b0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    model_reset();
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%0d ovr=%b, want 0/0/0", out_valid, out_data, overrun);
    end
`ifdef AVG_MINMAX_EN
    vectors++;
    if (out_min !== '0 || out_max !== '0) begin
      errors++;
      $display("FAIL reset_minmax: got min=%0d max=%0d, want 0/0", out_min, out_max);
    end
`endif
    rst = 1'b0;
    tick(); tick(); tick();
    sample_lo();
    out_ready = 1'b0;
    send(12'd100); send(12'd200); send(12'd300);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_high_level_counted: got valid=%b, want 0", out_valid);
    end
    sample_hi(12'd400);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd250) begin
      errors++;
      $display("FAIL reset_first_window: got valid=%b data=%0d, want 1/250", out_valid, out_data);
    end
    sample_lo();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_basic_mean();
    out_ready = 1'b1;
    send(12'd10); send(12'd20); send(12'd30);
    sample_hi(12'd40);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd25) begin
      errors++;
      $display("FAIL basic_mean: got valid=%b data=%0d, want 1/25", out_valid, out_data);
    end
    sample_lo();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_len: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    in_data = 12'd7; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    sample_lo();
    send(12'd7); send(12'd7);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_counted_once: got valid=%b after 3 samples, want 0", out_valid);
    end
    sample_hi(12'd7);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd7) begin
      errors++;
      $display("FAIL hold_window: got valid=%b data=%0d, want 1/7", out_valid, out_data);
    end
    sample_lo();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_truncation();
    out_ready = 1'b1;
    send(12'd1); send(12'd1); send(12'd1);
    sample_hi(12'd2);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd1) begin
      errors++;
      $display("FAIL trunc_mean: got valid=%b data=%0d, want 1/1", out_valid, out_data);
    end
    sample_lo();
    send(12'd4095); send(12'd4095); send(12'd4095);
    sample_hi(12'd4095);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd4095) begin
      errors++;
      $display("FAIL full_scale: got valid=%b data=%0d, want 1/4095", out_valid, out_data);
    end
    sample_lo();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'd5);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd5 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: got valid=%b data=%0d ovr=%b, want 1/5/0", out_valid, out_data, overrun);
    end
    send(12'd8); send(12'd10); send(12'd9); send(12'd9);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd9 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_overwrite: got valid=%b data=%0d ovr=%b, want 1/9/1", out_valid, out_data, overrun);
    end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b0 || out_valid !== 1'b1 || out_data !== 12'd9) begin
      errors++;
      $display("FAIL ovr_clear: got valid=%b data=%0d ovr=%b, want 1/9/0", out_valid, out_data, overrun);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_accept: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'd12);
    send(12'd20); send(12'd20); send(12'd20);
    out_ready = 1'b1;
    sample_hi(12'd24);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd21 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_replace: got valid=%b data=%0d ovr=%b, want 1/21/0", out_valid, out_data, overrun);
    end
    sample_lo();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got valid=%b, want 0", out_valid);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'd3);
    send(12'd6); send(12'd6); send(12'd6);
    clr_overrun = 1'b1;
    sample_hi(12'd6);
    clr_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || out_data !== 12'd6) begin
      errors++;
      $display("FAIL ovr_set_wins: got data=%0d ovr=%b, want 6/1", out_data, overrun);
    end
    sample_lo();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    out_ready = 1'b1; tick();
  endtask

  task automatic test_flush_and_reset();
    out_ready = 1'b1;
    send(12'd900); send(12'd800);
    flush = 1'b1; tick(); flush = 1'b0;
    send(12'd100); send(12'd100); send(12'd100);
    sample_hi(12'd100);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd100) begin
      errors++;
      $display("FAIL flush_window: got valid=%b data=%0d, want 1/100", out_valid, out_data);
    end
    sample_lo();
    send(12'd11);
    flush = 1'b1; sample_hi(12'd500); flush = 1'b0;
    sample_lo();
    send(12'd50); send(12'd50); send(12'd50);
    sample_hi(12'd50);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd50) begin
      errors++;
      $display("FAIL flush_same_cycle: got valid=%b data=%0d, want 1/50", out_valid, out_data);
    end
    sample_lo();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(12'd200);
    send(12'd1); send(12'd2); send(12'd3);
    rst = 1'b1; tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== '0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midwindow_reset: got valid=%b data=%0d ovr=%b, want 0/0/0", out_valid, out_data, overrun);
    end
    rst = 1'b0; tick();
    send(12'd40); send(12'd44); send(12'd48);
    sample_hi(12'd52);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 12'd46) begin
      errors++;
      $display("FAIL post_reset_window: got valid=%b data=%0d, want 1/46", out_valid, out_data);
    end
    sample_lo();
    out_ready = 1'b1; tick();
  endtask

  task automatic test_passthrough();
    sample_hi(12'd1234);
    vectors++;
    if (p_out_valid !== 1'b1 || p_out_data !== 12'd1234) begin
      errors++;
      $display("FAIL passthrough: got valid=%b data=%0d, want 1/1234", p_out_valid, p_out_data);
    end
    sample_lo();
    vectors++;
    if (p_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_drain: got valid=%b, want 0", p_out_valid);
    end
  endtask

`ifdef AVG_MINMAX_EN
  task automatic test_minmax();
    out_ready = 1'b1;
    flush = 1'b1; tick(); flush = 1'b0;
    send(12'd3); send(12'd9); send(12'd1);
    sample_hi(12'd5);
    vectors++;
    if (out_min !== 12'd1 || out_max !== 12'd9 || out_data !== 12'd4) begin
      errors++;
      $display("FAIL minmax: got min=%0d max=%0d data=%0d, want 1/9/4", out_min, out_max, out_data);
    end
    sample_lo();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = DW'($urandom_range(0, (1 << DW) - 1));
      flush       = ($urandom_range(0, 29) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      clr_overrun = ($urandom_range(0, 9) == 0);
      tick();
      vectors++;
      if (out_valid !== m_valid || out_data !== m_data || overrun !== m_ovr) begin
        errors++;
        $display("FAIL random_main cyc %0d: got valid=%b data=%0d ovr=%b, want %b/%0d/%b",
                 i, out_valid, out_data, overrun, m_valid, m_data, m_ovr);
      end
      vectors++;
      if (p_out_valid !== pm_valid || p_out_data !== pm_data || p_overrun !== 1'b0) begin
        errors++;
        $display("FAIL random_pass cyc %0d: got valid=%b data=%0d ovr=%b, want %b/%0d/0",
                 i, p_out_valid, p_out_data, p_overrun, pm_valid, pm_data);
      end
`ifdef AVG_MINMAX_EN
      vectors++;
      if (out_min !== m_min || out_max !== m_max) begin
        errors++;
        $display("FAIL random_minmax cyc %0d: got min=%0d max=%0d, want %0d/%0d",
                 i, out_min, out_max, m_min, m_max);
      end
`endif
    end
    in_valid = 1'b0; flush = 1'b0; clr_overrun = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_mean();
    test_hold();
    test_truncation();
    test_overrun();
    test_back_to_back();
    test_flush_and_reset();
    test_passthrough();
`ifdef AVG_MINMAX_EN
    test_minmax();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
